lfsr_range_gen: RTL and testbench
=================================

Name: lfsr_range_gen

Overview:
- Parametrised pseudo-random number source for game and test logic.
- A free-running Fibonacci LFSR feeds a fixed-latency restoring divider, which reduces a captured sample modulo a runtime range.
- The result is returned through a valid/ready handshake.
- Successor to the 3-bit mod-5 generator: width, taps and sample size are parametrised, the range is runtime, and latency is deterministic.

Parameters:
- LFSR_W, 16, LFSR register width (≥ SAMPLE_W, ≥ 4).
- TAPS, 16'hB400, feedback mask; bit i set means lfsr[i] participates in the XOR.
- SEED_DEFAULT, 16'h0001, value loaded by reset; must be nonzero.
- SAMPLE_W, 8, number of LFSR LSBs used as the dividend.
- OUT_W, 4, width of the range and result.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- seed_load  in  1  synchronous strobe: load seed into the LFSR.
- seed  in  LFSR_W  seed value.
- req  in  1  request a number; sampled only in IDLE.
- range  in  OUT_W  modulus N; captured on request acceptance.
- busy  out  1  high in DIV and DONE.
- num_valid  out  1  result available.
- num_ready  in  1  consumer accepts the result.
- num  out  OUT_W  result, in the range 0..N-1.
- range_err  out  1  high with num_valid when the captured N was 0.

Behaviour:
- Reset (reset=0, async):
  - lfsr=SEED_DEFAULT, state=IDLE.
  - num=0, num_valid=0, range_err=0, busy=0.
  - Aborts any operation in flight; no partial result is emitted.
- LFSR:
  - Advances every cycle out of reset: next = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)}.
  - seed_load=1 overrides the advance: lfsr<=seed, or lfsr<=1 if seed==0 (zero-lock guard).
  - The LFSR keeps running in all FSM states.
- FSM: IDLE -> DIV -> DONE -> IDLE.
  - IDLE: on req=1, capture dvd=lfsr[SAMPLE_W-1:0] (the pre-edge value), capture N=range, clear the counter, and go to DIV.
    - With seed_load and req in the same cycle, the sample is the old LFSR value.
  - DIV: one restoring shift-subtract step per cycle, MSB first.
    - Remainder register is OUT_W+1 bits; the quotient is discarded.
    - After exactly SAMPLE_W steps, load num=remainder[OUT_W-1:0], assert num_valid, and go to DONE.
    - If N==0: skip the arithmetic but still take SAMPLE_W cycles; num=0, range_err=1.
  - DONE:
    - num, num_valid and range_err hold stable until num_ready=1.
    - On the num_ready edge: num_valid=0, range_err=0, return to IDLE. num keeps its last value.
    - req is ignored outside IDLE.
- Latency: num_valid rises SAMPLE_W clock edges after the accepting edge.
  - Minimum spacing between results is SAMPLE_W+2 cycles (with num_ready held high).
- num_ready while not in DONE has no effect.
- Invariant: when range_err=0, num < N.

Optional Feature:
- Macro: LFSR_RANGE_GEN_COUNT_EN.
- Defined:
  - Adds output gen_count [15:0].
  - Reset to 0; increments on each completed handshake (num_valid & num_ready), including range_err results.
  - Wraps from 16'hFFFF to 0.
  - seed_load does not clear it.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then run 12 cycles with defaults -> lfsr goes 0x0001, 0x0002, …, 0x0400, then 0x0801; all outputs 0 during reset.
- seed_load with seed=0x00C8 at cycle t; req=1, range=7 at t+1; num_ready=1 -> num_valid rises 8 edges after acceptance; num=4 (200 mod 7); range_err=0.
- Same sample with range=0 -> num=0, range_err=1, same 8-cycle latency; both flags clear on num_ready.
- Hold num_ready=0 for 20 cycles in DONE and toggle req and range -> num, num_valid and busy stay stable; no new request is accepted until after the handshake.
- seed_load with seed=0 -> lfsr=0x0001 next cycle. Then assert reset mid-DIV (step 3) -> busy=0 and num_valid=0 immediately; no result after reset is released.
- With LFSR_RANGE_GEN_COUNT_EN defined: 3 back-to-back requests with num_ready held high -> gen_count=3. Preload to force 0xFFFF, complete one more request -> gen_count=0.

Source files
------------

// File: rtl/lfsr_range_gen_if.sv
// Request/result bundle for lfsr_range_gen: seeding, request, and the
// num valid/ready return channel.
interface lfsr_range_gen_if #(
  parameter int unsigned LFSR_W = 16,
  parameter int unsigned OUT_W  = 4
);
  logic              seed_load;
  logic [LFSR_W-1:0] seed;
  logic              req;
  logic [OUT_W-1:0]  range;
  logic              busy;
  logic              num_valid;
  logic              num_ready;
  logic [OUT_W-1:0]  num;
  logic              range_err;

  modport master (
    output seed_load, seed, req, range, num_ready,
    input  busy, num_valid, num, range_err
  );

  modport slave (
    input  seed_load, seed, req, range, num_ready,
    output busy, num_valid, num, range_err
  );
endinterface

// File: rtl/lfsr_range_gen.sv
// Free-running Fibonacci LFSR sampled into a fixed-latency restoring divider
// that returns sample mod N. Optional gen_count output: LFSR_RANGE_GEN_COUNT_EN.
module lfsr_range_gen #(
  parameter int unsigned         LFSR_W       = 16,
  parameter logic [LFSR_W-1:0]   TAPS         = LFSR_W'(16'hB400),
  parameter logic [LFSR_W-1:0]   SEED_DEFAULT = LFSR_W'(16'h0001),
  parameter int unsigned         SAMPLE_W     = 8,
  parameter int unsigned         OUT_W        = 4
) (
  input  logic                clk,
  input  logic                reset,
  lfsr_range_gen_if.slave     bus
`ifdef LFSR_RANGE_GEN_COUNT_EN
  ,
  output logic [15:0]         gen_count
`endif
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_W + 1);
  localparam int unsigned REM_W = OUT_W + 1;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t              state, state_n;
  logic [LFSR_W-1:0]   lfsr, lfsr_n;
  logic [SAMPLE_W-1:0] dvd, dvd_n;
  logic [REM_W-1:0]    rem, rem_n;
  logic [OUT_W-1:0]    modn, modn_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [OUT_W-1:0]    num_q, num_n;
  logic                valid_q, valid_n;
  logic                err_q, err_n;
  logic                busy_q, busy_n;
  logic [REM_W-1:0]    trial;
  logic [REM_W-1:0]    step_rem;

  // LFSR advance with seed override; a zero seed would lock the register
  always_comb begin
    lfsr_n = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
    if (bus.seed_load) begin
      lfsr_n = (bus.seed == '0) ? LFSR_W'(1) : bus.seed;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= SEED_DEFAULT;
    else        lfsr <= lfsr_n;
  end

  // One restoring shift-subtract step, dividend MSB first
  always_comb begin
    trial = {rem[OUT_W-1:0], dvd[SAMPLE_W-1]};
    if (trial >= {1'b0, modn}) step_rem = trial - {1'b0, modn};
    else                       step_rem = trial;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    dvd_n   = dvd;
    rem_n   = rem;
    modn_n  = modn;
    cnt_n   = cnt;
    num_n   = num_q;
    valid_n = valid_q;
    err_n   = err_q;
    case (state)
      IDLE: begin
        if (bus.req) begin
          dvd_n   = lfsr[SAMPLE_W-1:0];
          modn_n  = bus.range;
          rem_n   = '0;
          cnt_n   = '0;
          state_n = DIV;
        end
      end
      DIV: begin
        dvd_n = {dvd[SAMPLE_W-2:0], 1'b0};
        cnt_n = cnt + CNT_W'(1);
        if (modn != '0) rem_n = step_rem;
        if (cnt == CNT_W'(SAMPLE_W - 1)) begin
          state_n = DONE;
          valid_n = 1'b1;
          if (modn == '0) begin
            num_n = '0;
            err_n = 1'b1;
          end else begin
            num_n = step_rem[OUT_W-1:0];
            err_n = 1'b0;
          end
        end
      end
      DONE: begin
        if (bus.num_ready) begin
          valid_n = 1'b0;
          err_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvd     <= '0;
      rem     <= '0;
      modn    <= '0;
      cnt     <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      dvd     <= dvd_n;
      rem     <= rem_n;
      modn    <= modn_n;
      cnt     <= cnt_n;
      num_q   <= num_n;
      valid_q <= valid_n;
      err_q   <= err_n;
      busy_q  <= busy_n;
    end
  end

  assign bus.num       = num_q;
  assign bus.num_valid = valid_q;
  assign bus.range_err = err_q;
  assign bus.busy      = busy_q;

`ifdef LFSR_RANGE_GEN_COUNT_EN
  // Completed handshakes, error results included; wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         gen_count <= '0;
    else if (valid_q && bus.num_ready)  gen_count <= gen_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lfsr_range_gen.sv
// Scoreboard bench for lfsr_range_gen: a behavioural model pushes expected
// results on request acceptance; they are popped when num_valid rises.
module tb_lfsr_range_gen;
  localparam int unsigned LFSR_W   = 16;
  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned OUT_W    = 4;
  localparam logic [LFSR_W-1:0] TAPS = 16'hB400;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lfsr_range_gen_if #(.LFSR_W(LFSR_W), .OUT_W(OUT_W)) bus ();
`ifdef LFSR_RANGE_GEN_COUNT_EN
  logic [15:0] gen_count;
`endif

  lfsr_range_gen #(
    .LFSR_W(LFSR_W), .TAPS(TAPS), .SEED_DEFAULT(16'h0001),
    .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef LFSR_RANGE_GEN_COUNT_EN
    ,
    .gen_count(gen_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [LFSR_W-1:0]   m_lfsr = 16'h0001;
  int                  m_state = 0;
  int                  m_cnt = 0;
  logic                m_valid = 1'b0;
  int                  m_edge = 0;
  logic [15:0]         m_count = 16'h0;
  logic [SAMPLE_W-1:0] m_smp;
  logic [OUT_W:0]      m_exp;
  logic [OUT_W:0]      exp_q[$];
  int                  acc_q[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lfsr  = 16'h0001;
      m_state = 0;
      m_cnt   = 0;
      m_valid = 1'b0;
      m_count = 16'h0;
      exp_q.delete();
      acc_q.delete();
    end else begin
      m_edge++;
      m_smp = m_lfsr[SAMPLE_W-1:0];
      case (m_state)
        0: if (bus.req) begin
          if (bus.range == '0) m_exp = {1'b1, OUT_W'(0)};
          else                 m_exp = {1'b0, OUT_W'(32'(m_smp) % 32'(bus.range))};
          exp_q.push_back(m_exp);
          acc_q.push_back(m_edge);
          m_cnt   = 0;
          m_state = 1;
        end
        1: if (m_cnt == SAMPLE_W - 1) begin
          m_state = 2;
          m_valid = 1'b1;
        end else m_cnt++;
        default: if (bus.num_ready) begin
          m_valid = 1'b0;
          m_state = 0;
          m_count = m_count + 16'd1;
        end
      endcase
      if (bus.seed_load) m_lfsr = (bus.seed == '0) ? LFSR_W'(1) : bus.seed;
      else               m_lfsr = {m_lfsr[LFSR_W-2:0], ^(m_lfsr & TAPS)};
    end
  end

  logic             prev_valid = 1'b0;
  logic [OUT_W-1:0] hold_num = '0;
  logic             hold_err = 1'b0;
  int               pops = 0;

  task automatic sample();
    logic [OUT_W:0] e;
    int a;
    check("lfsr", dut.lfsr, m_lfsr);
    check("busy", bus.busy, m_state != 0);
    check("num_valid", bus.num_valid, m_valid);
    if (bus.num_valid && !prev_valid) begin
      check("sb_depth", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        hold_num = e[OUT_W-1:0];
        hold_err = e[OUT_W];
        check("latency", m_edge - a, SAMPLE_W);
        pops++;
      end
    end
    if (!reset) hold_num = '0;
    check("num", bus.num, hold_num);
    check("range_err", bus.range_err, m_valid ? hold_err : 1'b0);
`ifdef LFSR_RANGE_GEN_COUNT_EN
    check("gen_count", gen_count, m_count);
`endif
    prev_valid = bus.num_valid;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!bus.num_valid && n < max) begin
      tick();
      n++;
    end
    check("wait_valid", bus.num_valid, 1);
  endtask

  task automatic request(input logic [LFSR_W-1:0] s, input logic [OUT_W-1:0] r);
    bus.seed = s;
    bus.seed_load = 1'b1;
    tick();
    bus.seed_load = 1'b0;
    bus.req = 1'b1;
    bus.range = r;
    tick();
    bus.req = 1'b0;
  endtask

  initial begin
    int p0;
    int n;
    logic [LFSR_W-1:0] exp_l;
    bus.seed_load = 1'b0;
    bus.seed      = '0;
    bus.req       = 1'b0;
    bus.range     = '0;
    bus.num_ready = 1'b0;

    // Reset values, then the free-running sequence from the default seed
    repeat (3) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.num_valid, 0);
    reset = 1'b1;
    check("lfsr_init", dut.lfsr, 16'h0001);
    for (int j = 1; j <= 11; j++) begin
      tick();
      exp_l = (j <= 10) ? LFSR_W'(1 << j) : 16'h0801;
      check("lfsr_seq", dut.lfsr, exp_l);
    end

    // 200 mod 7
    bus.num_ready = 1'b1;
    request(16'h00C8, 4'd7);
    wait_valid(SAMPLE_W + 4);
    check("num_200_7", bus.num, 4);
    check("err_200_7", bus.range_err, 0);
    tick();
    check("hs_valid", bus.num_valid, 0);

    // N = 0
    request(16'h00C8, 4'd0);
    wait_valid(SAMPLE_W + 4);
    check("num_n0", bus.num, 0);
    check("err_n0", bus.range_err, 1);
    tick();
    check("clr_err", bus.range_err, 0);
    check("clr_valid", bus.num_valid, 0);

    // Stall in DONE while req/range toggle
    bus.num_ready = 1'b0;
    request(16'h1234, 4'd5);
    wait_valid(SAMPLE_W + 4);
    for (int i = 0; i < 20; i++) begin
      bus.req = 1'($urandom);
      bus.range = OUT_W'($urandom);
      tick();
      check("stall_busy", bus.busy, 1);
    end
    bus.req = 1'b0;
    bus.num_ready = 1'b1;
    tick();
    check("stall_release", bus.num_valid, 0);
    repeat (3) tick();
    check("no_accept", bus.busy, 0);

    // Zero-seed guard, then reset in the middle of a division
    bus.seed = '0;
    bus.seed_load = 1'b1;
    tick();
    bus.seed_load = 1'b0;
    check("zero_guard", dut.lfsr, 16'h0001);
    bus.req = 1'b1;
    bus.range = 4'd9;
    tick();
    bus.req = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    sample();
    check("abort_busy", bus.busy, 0);
    check("abort_valid", bus.num_valid, 0);
    repeat (2) tick();
    reset = 1'b1;
    p0 = pops;
    repeat (15) tick();
    check("no_result", pops, p0);

    // Back-to-back requests, num_ready held high
    p0 = pops;
    n = 0;
    bus.range = 4'd11;
    bus.req = 1'b1;
    while (pops < p0 + 3 && n < 60) begin
      tick();
      n++;
    end
    bus.req = 1'b0;
    check("b2b_results", pops, p0 + 3);
    tick();
`ifdef LFSR_RANGE_GEN_COUNT_EN
    check("count_3", gen_count, 3);
    force dut.gen_count = 16'hFFFF;
    m_count = 16'hFFFF;
    #1;
    release dut.gen_count;
    request(16'h0055, 4'd3);
    wait_valid(SAMPLE_W + 4);
    tick();
    check("count_wrap", gen_count, 0);
`endif

    // Random seeds and ranges with random consumer delay
    for (int i = 0; i < 12; i++) begin
      bus.num_ready = 1'b0;
      request(LFSR_W'($urandom), OUT_W'($urandom));
      wait_valid(SAMPLE_W + 4);
      repeat ($urandom_range(0, 3)) tick();
      bus.num_ready = 1'b1;
      tick();
      check("rand_hs", bus.num_valid, 0);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
